// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between pc_sequencer and imem.
// master drives request/address; slave returns ack/data.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer (IDLE/FETCH/EXEC/HALT).
// Optional jr alignment trap: define PC_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_sequencer_if.master        imem,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  input  logic                  stall,
  input  logic                  branch,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_offset,
  input  logic                  jump,
  input  logic [25:0]           jump_index,
  input  logic                  jr,
  input  logic [31:0]           jr_target,
  input  logic                  halt,
  output logic [31:0]           pc,
  output logic [31:0]           pc_plus4,
  output logic                  halted,
  output logic                  misalign
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] npc;
  logic        go_halt;
  logic        unused_bits;

  assign unused_bits = ^{branch_offset[31:30], jr_target[1:0]};

  assign pc_plus4       = pc + 32'd4;
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == EXEC);

`ifdef PC_ALIGN_CHECK_EN
  logic set_mis;
`endif

  always_comb begin
    npc     = pc_plus4;
    go_halt = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    set_mis = 1'b0;
`endif
    if (halt) begin
      npc     = pc;
      go_halt = 1'b1;
    end else if (jr) begin
`ifdef PC_ALIGN_CHECK_EN
      if (jr_target[1:0] != 2'b00) begin
        npc     = pc;
        go_halt = 1'b1;
        set_mis = 1'b1;
      end else begin
        npc = jr_target;
      end
`else
      npc = {jr_target[31:2], 2'b00};
`endif
    end else if (jump) begin
      npc = {pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch && branch_taken) begin
      // word offset: top two bits fall off the shift
      npc = pc_plus4 + {branch_offset[29:0], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      instr  <= 32'h0;
      halted <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem.imem_ack) begin
            instr <= imem.imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc <= npc;
            if (go_halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (state == EXEC && !stall && set_mis) begin
      misalign <= 1'b1;
    end
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected fetch addresses
// are queued at each EXEC decision and popped at each fetch.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'h0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        misalign;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (bus),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .stall         (stall),
    .branch        (branch),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .halt          (halt),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .halted        (halted),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic fetch(input int waits);
    int n = 0;
    logic [31:0] exp;
    bus.imem_ack = 1'b0;
    while (!bus.imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus.imem_req) begin
      chk("req_timeout", {31'b0, bus.imem_req}, 32'd1);
      return;
    end
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("wait_req", {31'b0, bus.imem_req}, 32'd1);
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    chk("fetch_addr", bus.imem_addr, exp);
    m_pc            = exp;
    m_instr         = 32'hA500_0000 ^ exp;
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = m_instr;
    @(negedge clk);
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    chk("instr", instr, m_instr);
    chk("ivalid", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic exec(input logic br, input logic tk,
                      input logic [31:0] off,
                      input logic jmp, input logic [25:0] idx,
                      input logic j_r, input logic [31:0] jt,
                      input logic hlt, input int stalls,
                      input logic [31:0] exp_pc,
                      input logic exp_halt,
                      input logic exp_mis);
    int vcnt = 0;
    branch        = br;
    branch_taken  = tk;
    branch_offset = off;
    jump          = jmp;
    jump_index    = idx;
    jr            = j_r;
    jr_target     = jt;
    halt          = hlt;
    stall         = (stalls > 0);
    if (instr_valid) vcnt++;
    for (int i = 0; i < stalls; i++) begin
      @(negedge clk);
      chk("stall_pc", pc, m_pc);
      if (instr_valid) vcnt++;
    end
    stall = 1'b0;
    if (!exp_halt) sb_q.push_back(exp_pc);
    @(negedge clk);
    {branch, branch_taken, jump, jr, halt} = 5'b0;
    if (stalls > 0)
      chk("valid_cycles", vcnt, stalls + 1);
    chk("halted", {31'b0, halted}, {31'b0, exp_halt});
    chk("misalign", {31'b0, misalign}, {31'b0, exp_mis});
    if (exp_halt) chk("halt_pc", pc, exp_pc);
  endtask

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ivalid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_plus4", pc_plus4, 32'h4);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    rst = 1'b0;
    chk("idle_req", {31'b0, bus.imem_req}, 32'd0);

    sb_q.push_back(32'h0);
    fetch(0);
    exec(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0, 0);
    chk("seq_ivalid_gap", {31'b0, instr_valid}, 32'd0);
    fetch(0);
    exec(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 0, 0);
    fetch(2);
    exec(0, 0, 0, 1, 26'h40, 0, 0, 0, 0, 32'h100, 0, 0);
    fetch(0);
    exec(1, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0,
         32'h0FC, 0, 0);
    fetch(0);
    exec(0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 32'h100, 0, 0);
    fetch(1);
    exec(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0);
    fetch(0);
    exec(0, 0, 0, 0, 0, 1, 32'hF000_0010, 0, 0,
         32'hF000_0010, 0, 0);
    fetch(0);
    exec(1, 1, 32'h4, 1, 26'h40, 0, 0, 0, 0,
         32'hF000_0100, 0, 0);
    fetch(0);
    exec(0, 0, 0, 0, 0, 1, 32'h200, 0, 3, 32'h200, 0, 0);
    fetch(0);
`ifdef PC_ALIGN_CHECK_EN
    exec(0, 0, 0, 0, 0, 1, 32'h203, 0, 0, 32'h200, 1, 1);
`else
    exec(0, 0, 0, 0, 0, 1, 32'h203, 0, 0, 32'h200, 0, 0);
    chk("jr_force_addr", bus.imem_addr, 32'h200);
`endif

    // async reset with an ack presented in the same cycle
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_ivalid", {31'b0, instr_valid}, 32'd0);
    chk("arst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_halted", {31'b0, halted}, 32'd0);
    chk("arst_mis", {31'b0, misalign}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    chk("drop_instr", instr, 32'h0);
    chk("rel_req", {31'b0, bus.imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'b0, bus.imem_req}, 32'd1);

    sb_q.delete();
    sb_q.push_back(32'h0);
    fetch(0);
    exec(0, 0, 0, 1, 26'h3, 1, 32'h300, 1, 0, 32'h0, 1, 0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hFFFF_0000;
    jr = 1'b1;
    jr_target = 32'h400;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("frz_req", {31'b0, bus.imem_req}, 32'd0);
      chk("frz_pc", pc, 32'h0);
      chk("frz_instr", instr, m_instr);
      chk("frz_halted", {31'b0, halted}, 32'd1);
    end
    jr = 1'b0;
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("unhalt", {31'b0, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_req", {31'b0, bus.imem_req}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

- Owns the program counter and sequences instruction fetch for the single-cycle processor.
- Handshakes with instruction memory and presents each fetched instruction to decode.
- Samples decode's control-flow outcome: sequential, taken branch, jump, jump-register or halt.
- Computes the next PC, including the word-offset shift (offset << 2) for branch and jump targets.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  memory returns imem_rdata this cycle; ignored outside FETCH.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  registered instruction to decode.
- instr_valid  out  1  high while in EXEC.
- stall  in  1  decode/execute not ready; holds EXEC.
- branch  in  1  current instruction is a conditional branch.
- branch_taken  in  1  branch condition true.
- branch_offset  in  32  sign-extended word offset.
- jump  in  1  absolute jump.
- jump_index  in  26  jump word index.
- jr  in  1  jump-register.
- jr_target  in  32  register byte address.
- halt  in  1  stop after this instruction.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, combinational; link value for decode.
- halted  out  1  high in HALT.
- misalign  out  1  sticky jr-misalignment flag (see Configuration).

## Operation
FSM states: IDLE, FETCH, EXEC, HALT.

State transitions:
- IDLE -> FETCH unconditionally, one cycle after rst deasserts.
- FETCH: imem_req=1 and imem_addr=pc. On imem_ack, load imem_rdata into instr and go to EXEC. Otherwise stay in FETCH with pc unchanged.
- EXEC: instr_valid=1. Control inputs are sampled only in EXEC with stall=0.
  - If stall=1: stay in EXEC; instr, pc and instr_valid are held.
  - If stall=0: update pc per the priority rule below, then go to FETCH, or to HALT when halt is sampled.
- HALT: pc, instr and outputs are frozen. Only rst exits HALT.

Next-PC priority, highest first:
- halt: pc unchanged.
- jr: pc = jr_target.
- jump: pc = {pc_plus4[31:28], jump_index, 2'b00}.
- branch & branch_taken: pc = pc_plus4 + (branch_offset << 2).
- Otherwise: pc = pc_plus4.

Arithmetic rules:
- All sums are 32-bit and wrap modulo 2^32; there is no overflow detection.
- The shift discards branch_offset[31:30].
- branch=1 with branch_taken=0 is a sequential step.

Boundary conditions:
- Multiple controls asserted together resolve by the priority rule.
- imem_ack held high continuously: every FETCH completes in one cycle.
- Asynchronous rst in any state, including mid-fetch or mid-stall, immediately sets:
  - pc=RESET_PC, state=IDLE
  - instr=0, instr_valid=0, imem_req=0
  - halted=0, misalign=0
- An ack in flight at reset is dropped.

## Timing
- Reset values: pc=RESET_PC; instr=32'h0; instr_valid, imem_req, halted, misalign all 0; imem_addr=RESET_PC; pc_plus4=RESET_PC+4.
- imem_req rises the first clock edge after rst release.
- Minimum throughput: 2 cycles per instruction (FETCH with same-cycle ack, then EXEC).
- Each wait cycle (ack low) or stall cycle adds one cycle.
- pc, instr, state, halted and misalign are registered. imem_req, imem_addr, instr_valid and pc_plus4 are decoded combinationally from registers.
- The new pc is visible on imem_addr in the FETCH cycle immediately following the EXEC cycle that sampled the controls.

## Configuration
Macro: PC_ALIGN_CHECK_EN.

When defined:
- A jr sampled with jr_target[1:0] != 0 does not update pc.
- The FSM enters HALT and misalign is set; misalign stays high until rst.

When undefined:
- jr_target[1:0] is forced to 2'b00 and the jump proceeds.
- misalign is tied to 0.

## Test plan
- Reset then free-running ack with no control inputs: imem_addr sequence 0x0, 0x4, 0x8; instr_valid high every second cycle.
- At pc=0x100, branch=1, branch_taken=1, branch_offset=32'hFFFF_FFFE: next fetch at 0x0FC. With branch_taken=0: next fetch at 0x104.
- At pc=0xF000_0010, jump=1 asserted together with a taken branch, jump_index=26'h000_0040: next fetch at 0xF000_0100 (jump wins).
- stall held 3 cycles in EXEC, with jr=1 and jr_target=0x200 throughout: instr_valid high for 4 cycles; pc=0x200 only after stall drops.
- jr_target=0x203:
  - With PC_ALIGN_CHECK_EN: halted=1 and misalign=1, pc unchanged.
  - Without it: next fetch at 0x200 and misalign=0.
- Assert rst mid-FETCH with ack pending, then release: pc=RESET_PC, instr_valid=0, and the first request is issued one cycle later. halt then freezes the block until a subsequent reset.
